cv32e40p_alu_permanent_fault_detector: RTL and testbench

- Sits directly upstream of the ALU-replica selection decoder. Drives the 4-bit per-ALU permanent-fault vector that the decoder consumes.
- Observes per-ALU mismatch flags from the TMR voter on every voted ALU operation.
- Runs a leaky-bucket error counter per ALU. Transient errors decay away; repeated errors mark that ALU permanently faulty (sticky).

---
 rtl/cv32e40p_ft_pkg.sv | 9 +
 rtl/cv32e40p_alu_permanent_fault_detector_if.sv | 22 ++
 rtl/cv32e40p_alu_fault_counter.sv | 63 ++++++
 rtl/cv32e40p_alu_permanent_fault_detector.sv | 48 ++++
 tb/tb_cv32e40p_alu_permanent_fault_detector.sv | 127 ++++++++++++
 5 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// cv32e40p_ft_pkg: shared types and defaults for the ALU permanent-fault detector
package cv32e40p_ft_pkg;
  typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTY} alu_health_e;
  localparam int N_ALU_FT = 4;
  localparam int ALU_FT_CNT_W = 4;
  localparam int ALU_FT_THRESHOLD = 8;
  localparam int ALU_FT_WINDOW_W = 8;
  localparam int ALU_FT_WINDOW = 64;
endpackage

// File: rtl/cv32e40p_alu_permanent_fault_detector_if.sv
// cv32e40p_alu_permanent_fault_detector_if: voter observation bus and fault outputs
interface cv32e40p_alu_permanent_fault_detector_if #(
  parameter int N_ALU = 4,
  parameter int CNT_W = 4
);
  logic                   vote_valid_i;
  logic [N_ALU-1:0]       alu_mismatch_i;
  logic                   vote_uncorrectable_i;
  logic [N_ALU-1:0]       alu_active_i;
  logic                   clear_faults_i;
  logic [N_ALU-1:0]       permanent_faulty_alu_o;
  logic                   fault_event_o;
  logic [N_ALU*CNT_W-1:0] err_count_o;
  modport master (
    output vote_valid_i, alu_mismatch_i, vote_uncorrectable_i, alu_active_i, clear_faults_i,
    input  permanent_faulty_alu_o, fault_event_o, err_count_o
  );
  modport slave (
    input  vote_valid_i, alu_mismatch_i, vote_uncorrectable_i, alu_active_i, clear_faults_i,
    output permanent_faulty_alu_o, fault_event_o, err_count_o
  );
endinterface

// File: rtl/cv32e40p_alu_fault_counter.sv
// cv32e40p_alu_fault_counter: leaky-bucket error counter and health FSM for one ALU
module cv32e40p_alu_fault_counter
  import cv32e40p_ft_pkg::*;
#(
  parameter int CNT_W     = ALU_FT_CNT_W,
  parameter int THRESHOLD = ALU_FT_THRESHOLD,
  parameter int WINDOW_W  = ALU_FT_WINDOW_W,
  parameter int WINDOW    = ALU_FT_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             mismatch,
  input  logic             clear,
  output logic             flag,
  output logic [CNT_W-1:0] err_cnt
);
  alu_health_e         state_q, state_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [WINDOW_W-1:0] win_q, win_d;
  logic                flag_q, flag_d;
  logic                hit, expire, live;
  assign live   = count_en && state_q != FAULTY;
  assign hit    = err_q + CNT_W'(1) == CNT_W'(THRESHOLD);
  assign expire = win_q + WINDOW_W'(1) == WINDOW_W'(WINDOW);
  // an error on the same vote as window expiry takes the mismatch branch, so it wins
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    win_d   = win_q;
    flag_d  = flag_q;
    if (clear) begin
      state_d = HEALTHY;
      err_d   = '0;
      win_d   = '0;
      flag_d  = 1'b0;
    end else if (live && mismatch) begin
      state_d = hit ? FAULTY : SUSPECT;
      err_d   = err_q + CNT_W'(1);
      win_d   = '0;
      flag_d  = hit;
    end else if (live && state_q == SUSPECT) begin
      state_d = expire && err_q == CNT_W'(1) ? HEALTHY : SUSPECT;
      err_d   = expire ? err_q - CNT_W'(1) : err_q;
      win_d   = expire ? '0 : win_q + WINDOW_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEALTHY;
      err_q   <= '0;
      win_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      win_q   <= win_d;
      flag_q  <= flag_d;
    end
  end
  assign flag    = flag_q;
  assign err_cnt = err_q;
endmodule

// File: rtl/cv32e40p_alu_permanent_fault_detector.sv
// cv32e40p_alu_permanent_fault_detector: vote qualification, per-ALU counters, fault event pulse
module cv32e40p_alu_permanent_fault_detector
  import cv32e40p_ft_pkg::*;
#(
  parameter int N_ALU     = N_ALU_FT,
  parameter int CNT_W     = ALU_FT_CNT_W,
  parameter int THRESHOLD = ALU_FT_THRESHOLD,
  parameter int WINDOW_W  = ALU_FT_WINDOW_W,
  parameter int WINDOW    = ALU_FT_WINDOW
) (
  input logic clk,
  input logic rst,
  cv32e40p_alu_permanent_fault_detector_if.slave bus
);
  logic [N_ALU-1:0]            count_en, flag_w, crossing;
  logic [N_ALU-1:0][CNT_W-1:0] err_w;
  logic                        fault_event_q, fault_event_d;
  genvar i;
  generate
    for (i = 0; i < N_ALU; i++) begin : g_alu
      assign count_en[i] = bus.vote_valid_i & ~bus.vote_uncorrectable_i & bus.alu_active_i[i];
      // the only non-faulty count one below threshold is the one about to cross
      assign crossing[i] = count_en[i] & bus.alu_mismatch_i[i] & (err_w[i] == CNT_W'(THRESHOLD - 1));
      cv32e40p_alu_fault_counter #(
        .CNT_W    (CNT_W),
        .THRESHOLD(THRESHOLD),
        .WINDOW_W (WINDOW_W),
        .WINDOW   (WINDOW)
      ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .count_en(count_en[i]),
        .mismatch(bus.alu_mismatch_i[i]),
        .clear   (bus.clear_faults_i),
        .flag    (flag_w[i]),
        .err_cnt (err_w[i])
      );
    end
  endgenerate
  always_comb fault_event_d = ~bus.clear_faults_i & |crossing;
  always_ff @(posedge clk) begin
    if (rst) fault_event_q <= 1'b0;
    else fault_event_q <= fault_event_d;
  end
  assign bus.permanent_faulty_alu_o = flag_w;
  assign bus.fault_event_o          = fault_event_q;
  assign bus.err_count_o            = err_w;
endmodule

// File: tb/tb_cv32e40p_alu_permanent_fault_detector.sv
// tb_cv32e40p_alu_permanent_fault_detector: directed vectors against hand-computed counts and flags
module tb_cv32e40p_alu_permanent_fault_detector;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  cv32e40p_alu_permanent_fault_detector_if #(.N_ALU(4), .CNT_W(4)) bus ();
  cv32e40p_alu_permanent_fault_detector dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.vote_valid_i         = 1'b0;
    bus.alu_mismatch_i       = 4'b0000;
    bus.vote_uncorrectable_i = 1'b0;
    bus.alu_active_i         = 4'b1111;
    bus.clear_faults_i       = 1'b0;
  endtask
  task automatic vote(input logic [3:0] m, input int n);
    bus.vote_valid_i   = 1'b1;
    bus.alu_mismatch_i = m;
    for (int k = 0; k < n; k++) tick();
    idle();
  endtask
  task automatic clear();
    bus.clear_faults_i = 1'b1;
    tick();
    idle();
  endtask
  initial begin
    rst = 1'b1;
    bus.vote_valid_i         = 1'b1;
    bus.alu_mismatch_i       = 4'($urandom);
    bus.vote_uncorrectable_i = 1'($urandom);
    bus.alu_active_i         = 4'($urandom);
    bus.clear_faults_i       = 1'($urandom);
    tick();
    bus.alu_mismatch_i = 4'($urandom);
    tick();
    check("reset_flags", 32'(bus.permanent_faulty_alu_o), 0);
    check("reset_err", 32'(bus.err_count_o), 0);
    check("reset_event", 32'(bus.fault_event_o), 0);
    idle();
    rst = 1'b0;
    tick();
    vote(4'b0010, 7);
    check("perm_7_err", 32'(bus.err_count_o), 32'h0070);
    check("perm_7_flag", 32'(bus.permanent_faulty_alu_o), 0);
    check("perm_7_event", 32'(bus.fault_event_o), 0);
    vote(4'b0010, 1);
    check("perm_8_flag", 32'(bus.permanent_faulty_alu_o), 32'b0010);
    check("perm_8_event", 32'(bus.fault_event_o), 1);
    check("perm_8_err", 32'(bus.err_count_o), 32'h0080);
    tick();
    check("perm_event_once", 32'(bus.fault_event_o), 0);
    vote(4'b0010, 3);
    check("perm_sat_err", 32'(bus.err_count_o), 32'h0080);
    check("perm_sat_event", 32'(bus.fault_event_o), 0);
    vote(4'b0000, 70);
    check("perm_sticky", 32'(bus.permanent_faulty_alu_o), 32'b0010);
    clear();
    check("clear_flags", 32'(bus.permanent_faulty_alu_o), 0);
    check("clear_err", 32'(bus.err_count_o), 0);
    vote(4'b0001, 3);
    check("leak_3", 32'(bus.err_count_o), 3);
    vote(4'b0000, 63);
    check("leak_63", 32'(bus.err_count_o), 3);
    vote(4'b0000, 1);
    check("leak_64", 32'(bus.err_count_o), 2);
    vote(4'b0000, 128);
    check("leak_192", 32'(bus.err_count_o), 0);
    vote(4'b0000, 64);
    check("leak_healthy_hold", 32'(bus.err_count_o), 0);
    check("leak_no_flag", 32'(bus.permanent_faulty_alu_o), 0);
    vote(4'b0001, 1);
    check("leak_restart", 32'(bus.err_count_o), 1);
    clear();
    bus.alu_active_i = 4'b1011;
    bus.vote_valid_i = 1'b1;
    bus.alu_mismatch_i = 4'b0100;
    for (int k = 0; k < 10; k++) tick();
    bus.alu_active_i = 4'b1111;
    bus.vote_uncorrectable_i = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    bus.vote_uncorrectable_i = 1'b0;
    bus.vote_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    idle();
    check("qual_err", 32'(bus.err_count_o), 0);
    check("qual_flag", 32'(bus.permanent_faulty_alu_o), 0);
    vote(4'b0001, 1);
    vote(4'b0000, 63);
    vote(4'b0001, 1);
    check("expire_err_wins", 32'(bus.err_count_o), 2);
    vote(4'b0000, 63);
    check("expire_win_reset", 32'(bus.err_count_o), 2);
    vote(4'b0000, 1);
    check("expire_decrement", 32'(bus.err_count_o), 1);
    vote(4'b0100, 7);
    check("clr_pre", 32'(bus.err_count_o), 32'h0701);
    bus.clear_faults_i = 1'b1;
    vote(4'b1111, 1);
    check("clr_vote_err", 32'(bus.err_count_o), 0);
    check("clr_vote_flag", 32'(bus.permanent_faulty_alu_o), 0);
    check("clr_vote_event", 32'(bus.fault_event_o), 0);
    vote(4'b1001, 8);
    check("dual_flags", 32'(bus.permanent_faulty_alu_o), 32'b1001);
    check("dual_event", 32'(bus.fault_event_o), 1);
    check("dual_err", 32'(bus.err_count_o), 32'h8008);
    tick();
    check("dual_event_once", 32'(bus.fault_event_o), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_flags", 32'(bus.permanent_faulty_alu_o), 0);
    check("rst_mid_err", 32'(bus.err_count_o), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
